// File: rtl/state_seq_driver.sv
// Drives NUM_VECTORS 128-bit vectors over valid/ready, with TRIG_PATTERN in slot TRIG_INDEX, and scores trig_in.
// Optional stall timeout is enabled by defining STATE_SEQ_DRIVER_TIMEOUT_EN.
module state_seq_driver #(
    parameter int unsigned  NUM_VECTORS  = 16,
    parameter int unsigned  TRIG_INDEX   = 5,
    parameter logic [127:0] TRIG_PATTERN = 128'h00112233_44556677_8899aabb_ccddeeff,
    parameter logic [127:0] SEED         = 128'h0123456789abcdef_fedcba9876543210,
    parameter int unsigned  GAP_CYCLES   = 2,
    parameter int unsigned  CHECK_WINDOW = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic [127:0] state_out,
    output logic         state_valid,
    input  logic         state_ready,
    input  logic         trig_in,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic         fail_early,
    output logic         fail_late,
    output logic [7:0]   vec_idx
`ifdef STATE_SEQ_DRIVER_TIMEOUT_EN
    ,
    output logic         timeout
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_GAP, S_WAIT, S_DONE} state_t;

    localparam logic [31:0] TRIG_IDX = 32'(TRIG_INDEX);
    localparam logic [7:0]  LAST_IDX = 8'(NUM_VECTORS - 1);
    localparam logic [3:0]  GAP_LAST = 4'(GAP_CYCLES - 1);
    localparam logic [3:0]  WIN_LAST = 4'(CHECK_WINDOW - 1);

    state_t       state_q, state_d;
    logic [127:0] lfsr, lfsr_next, filler;
    logic [3:0]   gap_cnt, wait_cnt, win_cnt, win_cnt_d;
    logic         pat_seen, pat_d, win_act, win_act_d, fe_d, fl_d;
    logic         accept, is_trig, last_vec, stall_to;

    assign accept    = state_valid & state_ready;
    assign is_trig   = (32'(vec_idx) == TRIG_IDX);
    assign last_vec  = (vec_idx == LAST_IDX);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    // Galois step for x^128 + x^7 + x^2 + x + 1
    assign lfsr_next = {lfsr[126:0], 1'b0} ^ (lfsr[127] ? 128'h87 : 128'h0);
    // A filler must never look like the pattern, or a negative run would fire the monitor
    assign filler    = (lfsr == TRIG_PATTERN) ? ~lfsr : lfsr;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_LOAD;
            S_LOAD: state_d = S_SEND;
            S_SEND: begin
                if (stall_to)
                    state_d = S_DONE;
                else if (accept) begin
                    if (last_vec)                state_d = S_WAIT;
                    else if (GAP_CYCLES == 32'd0) state_d = S_LOAD;
                    else                         state_d = S_GAP;
                end
            end
            S_GAP:  if (gap_cnt == GAP_LAST)  state_d = S_LOAD;
            S_WAIT: if (wait_cnt == WIN_LAST) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Scoring: trig_in in the acceptance cycle itself still counts as early
    always_comb begin
        fe_d      = fail_early;
        fl_d      = fail_late;
        pat_d     = pat_seen;
        win_act_d = win_act;
        win_cnt_d = win_cnt;
        if (busy) begin
            if (!pat_seen && trig_in) fe_d = 1'b1;
            if (win_act) begin
                if (trig_in)
                    win_act_d = 1'b0;
                else if (win_cnt == WIN_LAST) begin
                    fl_d      = 1'b1;
                    win_act_d = 1'b0;
                end else
                    win_cnt_d = win_cnt + 4'd1;
            end
            if (accept && is_trig) begin
                pat_d     = 1'b1;
                win_act_d = 1'b1;
                win_cnt_d = '0;
            end
            if (stall_to) fl_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            state_out   <= '0;
            state_valid <= 1'b0;
            pass        <= 1'b0;
            fail_early  <= 1'b0;
            fail_late   <= 1'b0;
            vec_idx     <= '0;
            lfsr        <= SEED;
            gap_cnt     <= '0;
            wait_cnt    <= '0;
            pat_seen    <= 1'b0;
            win_act     <= 1'b0;
            win_cnt     <= '0;
        end else begin
            state_q <= state_d;
            if (busy) begin
                fail_early <= fe_d;
                fail_late  <= fl_d;
                pat_seen   <= pat_d;
                win_act    <= win_act_d;
                win_cnt    <= win_cnt_d;
            end
            case (state_q)
                S_IDLE: if (start) begin
                    pass       <= 1'b0;
                    fail_early <= 1'b0;
                    fail_late  <= 1'b0;
                    vec_idx    <= '0;
                    lfsr       <= SEED;
                    pat_seen   <= 1'b0;
                    win_act    <= 1'b0;
                    win_cnt    <= '0;
                end
                S_LOAD: begin
                    state_out   <= is_trig ? TRIG_PATTERN : filler;
                    state_valid <= 1'b1;
                end
                S_SEND: begin
                    if (stall_to)
                        state_valid <= 1'b0;
                    else if (accept) begin
                        state_valid <= 1'b0;
                        if (!is_trig) lfsr <= lfsr_next;
                        gap_cnt  <= '0;
                        wait_cnt <= '0;
                        if (!last_vec && GAP_CYCLES == 32'd0) vec_idx <= vec_idx + 8'd1;
                    end
                end
                S_GAP: begin
                    gap_cnt <= gap_cnt + 4'd1;
                    if (gap_cnt == GAP_LAST) vec_idx <= vec_idx + 8'd1;
                end
                S_WAIT: wait_cnt <= wait_cnt + 4'd1;
                S_DONE: pass <= ~fe_d & ~fl_d;
                default: ;
            endcase
        end
    end

`ifdef STATE_SEQ_DRIVER_TIMEOUT_EN
    logic [7:0] stall_cnt;

    // Fires on the 255th consecutive stalled SEND cycle
    assign stall_to = (state_q == S_SEND) && !state_ready && (stall_cnt == 8'd254);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            timeout   <= 1'b0;
        end else begin
            if (state_q == S_IDLE && start) timeout <= 1'b0;
            if (state_q != S_SEND || state_ready) stall_cnt <= '0;
            else                                  stall_cnt <= stall_cnt + 8'd1;
            if (stall_to) timeout <= 1'b1;
        end
    end
`else
    assign stall_to = 1'b0;
`endif

endmodule

// File: tb/tb_state_seq_driver.sv
// Directed bench for state_seq_driver: default and negative-run instances, with a latching monitor model.
module tb_state_seq_driver;
    localparam logic [127:0] PAT  = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] SEED = 128'h0123456789abcdef_fedcba9876543210;
    localparam logic [127:0] V1   = 128'h02468acf13579bdf_fdb97530eca86420;

    logic clk = 0;
    always #5 clk = ~clk;

    logic rst, start_a, start_n, state_ready, trig_a, trig_n;
    logic [127:0] so_a, so_n;
    logic sv_a, sv_n, busy_a, busy_n, done_a, done_n, pass_a, pass_n;
    logic fe_a, fe_n, fl_a, fl_n;
    logic [7:0] idx_a, idx_n;
`ifdef STATE_SEQ_DRIVER_TIMEOUT_EN
    logic to_a, to_n;
`endif

    state_seq_driver u_a (
        .clk(clk), .rst(rst), .start(start_a), .state_out(so_a), .state_valid(sv_a),
        .state_ready(state_ready), .trig_in(trig_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .fail_early(fe_a), .fail_late(fl_a), .vec_idx(idx_a)
`ifdef STATE_SEQ_DRIVER_TIMEOUT_EN
        , .timeout(to_a)
`endif
    );

    state_seq_driver #(.TRIG_INDEX(20)) u_n (
        .clk(clk), .rst(rst), .start(start_n), .state_out(so_n), .state_valid(sv_n),
        .state_ready(state_ready), .trig_in(trig_n), .busy(busy_n), .done(done_n), .pass(pass_n),
        .fail_early(fe_n), .fail_late(fl_n), .vec_idx(idx_n)
`ifdef STATE_SEQ_DRIVER_TIMEOUT_EN
        , .timeout(to_n)
`endif
    );

    // Latching monitor: rises the cycle after the pattern is accepted
    int mon_mode;
    logic mon_q;
    always @(posedge clk) begin
        if (rst || start_a) mon_q <= 1'b0;
        else if (mon_mode == 0 && sv_a && state_ready && so_a == PAT) mon_q <= 1'b1;
    end
    assign trig_a = mon_q;

    logic sel;
    logic [127:0] m_out;
    logic m_valid, m_busy, m_done, m_fl;
    logic [7:0] m_idx;
    assign m_out   = sel ? so_n   : so_a;
    assign m_valid = sel ? sv_n   : sv_a;
    assign m_busy  = sel ? busy_n : busy_a;
    assign m_done  = sel ? done_n : done_a;
    assign m_fl    = sel ? fl_n   : fl_a;
    assign m_idx   = sel ? idx_n  : idx_a;

    int errors = 0, checks = 0;
    logic rand_ready, force_at3;
    logic [127:0] got_vec [32];
    logic [7:0]   got_idx [32];
    int got_n, done_cnt, stable_err, pat_cyc, fl_cyc;
    logic timed_out;

    function automatic logic [127:0] lfsr_step(input logic [127:0] v);
        return {v[126:0], 1'b0} ^ (v[127] ? 128'h87 : 128'h0);
    endfunction

    function automatic logic [127:0] gold_vec(input int i, input int tidx);
        logic [127:0] l;
        l = SEED;
        for (int k = 0; k < i; k++) if (k != tidx) l = lfsr_step(l);
        if (i == tidx) return PAT;
        return (l == PAT) ? ~l : l;
    endfunction

    // Pulses start on the selected instance and records every accepted vector until the run ends
    task automatic collect(input int budget);
        logic pv, pr, seen_done, ended;
        logic [127:0] po;
        got_n = 0; done_cnt = 0; stable_err = 0; pat_cyc = -1; fl_cyc = -1;
        pv = 0; pr = 0; po = '0; seen_done = 0; ended = 0;
        if (sel) start_n = 1; else start_a = 1;
        @(negedge clk);
        start_n = 0; start_a = 0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (seen_done && !m_busy) begin ended = 1; break; end
            if (rand_ready) state_ready = 1'($urandom_range(0, 1));
            if (force_at3 && m_busy && m_idx == 8'd3) trig_n = 1;
            if (pv && !pr && (!m_valid || m_out !== po)) stable_err++;
            if (m_valid && state_ready) begin
                if (got_n < 32) begin got_vec[got_n] = m_out; got_idx[got_n] = m_idx; end
                got_n++;
                if (m_out == PAT) pat_cyc = cyc;
            end
            if (m_fl && fl_cyc < 0) fl_cyc = cyc;
            if (m_done) begin done_cnt++; seen_done = 1; end
            pv = m_valid; pr = state_ready; po = m_out;
            @(negedge clk);
        end
        timed_out = !ended;
        rand_ready = 0; state_ready = 1;
    endtask

    task automatic test_reset();
        checks++; if ({so_a, sv_a, busy_a, done_a, pass_a, fe_a, fl_a, idx_a} !== '0) begin
            errors++; $display("FAIL reset_a: got out=%0h v=%b b=%b d=%b p=%b fe=%b fl=%b idx=%0d want all 0",
                so_a, sv_a, busy_a, done_a, pass_a, fe_a, fl_a, idx_a); end
        checks++; if ({so_n, sv_n, busy_n, done_n, pass_n, fe_n, fl_n, idx_n} !== '0) begin
            errors++; $display("FAIL reset_n: outputs not at reset values"); end
        rst = 0;
        @(negedge clk);
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy_a); end
    endtask

    task automatic test_basic();
        sel = 0; mon_mode = 0;
        collect(2000);
        checks++; if (timed_out) begin errors++; $display("FAIL basic_timeout: run did not end"); end
        checks++; if (got_n !== 16) begin errors++; $display("FAIL basic_count: got %0d want 16", got_n); end
        checks++; if (got_vec[0] !== SEED) begin errors++; $display("FAIL basic_v0: got %h want %h", got_vec[0], SEED); end
        checks++; if (got_vec[1] !== V1) begin errors++; $display("FAIL basic_v1: got %h want %h", got_vec[1], V1); end
        checks++; if (got_vec[5] !== PAT) begin errors++; $display("FAIL basic_v5: got %h want %h", got_vec[5], PAT); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (got_vec[i] !== gold_vec(i, 5) || got_idx[i] !== 8'(i)) begin
                errors++; $display("FAIL basic_seq[%0d]: got %h idx %0d want %h idx %0d", i, got_vec[i], got_idx[i], gold_vec(i, 5), i); end
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done: got %0d pulses want 1", done_cnt); end
        checks++; if ({pass_a, fe_a, fl_a} !== 3'b100) begin
            errors++; $display("FAIL basic_result: got pass=%b fe=%b fl=%b want 1 0 0", pass_a, fe_a, fl_a); end
    endtask

    task automatic test_late();
        sel = 0; mon_mode = 1;
        collect(2000);
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL late_done: got %0d want 1", done_cnt); end
        checks++; if (fl_cyc - pat_cyc !== 5) begin
            errors++; $display("FAIL late_timing: got %0d cycles want 5", fl_cyc - pat_cyc); end
        checks++; if ({pass_a, fe_a, fl_a} !== 3'b001) begin
            errors++; $display("FAIL late_result: got pass=%b fe=%b fl=%b want 0 0 1", pass_a, fe_a, fl_a); end
        mon_mode = 0;
    endtask

    task automatic test_negative();
        logic seen_pat;
        sel = 1; trig_n = 0;
        collect(2000);
        seen_pat = 0;
        for (int i = 0; i < 16; i++) begin
            if (got_vec[i] == PAT) seen_pat = 1;
            checks++; if (got_vec[i] !== gold_vec(i, 20)) begin
                errors++; $display("FAIL neg_seq[%0d]: got %h want %h", i, got_vec[i], gold_vec(i, 20)); end
        end
        checks++; if (seen_pat) begin errors++; $display("FAIL neg_nopat: got pattern want none"); end
        checks++; if ({pass_n, fe_n, fl_n, 8'(done_cnt)} !== {3'b100, 8'd1}) begin
            errors++; $display("FAIL neg_pass: got pass=%b fe=%b fl=%b done=%0d want 1 0 0 1", pass_n, fe_n, fl_n, done_cnt); end
        force_at3 = 1;
        collect(2000);
        force_at3 = 0; trig_n = 0;
        checks++; if ({pass_n, fe_n, fl_n} !== 3'b010) begin
            errors++; $display("FAIL neg_early: got pass=%b fe=%b fl=%b want 0 1 0", pass_n, fe_n, fl_n); end
        sel = 0;
    endtask

    task automatic test_backpressure();
        sel = 0; rand_ready = 1;
        collect(4000);
        checks++; if (stable_err !== 0) begin errors++; $display("FAIL bp_stable: got %0d changes want 0", stable_err); end
        checks++; if (got_n !== 16) begin errors++; $display("FAIL bp_count: got %0d want 16", got_n); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (got_vec[i] !== gold_vec(i, 5) || got_idx[i] !== 8'(i)) begin
                errors++; $display("FAIL bp_seq[%0d]: got %h idx %0d want %h", i, got_vec[i], got_idx[i], gold_vec(i, 5)); end
        end
        checks++; if (pass_a !== 1'b1) begin errors++; $display("FAIL bp_pass: got %b want 1", pass_a); end
    endtask

    task automatic test_reset_mid_run();
        logic found;
        sel = 0; found = 0;
        start_a = 1;
        @(negedge clk);
        start_a = 0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            if (sv_a && state_ready && idx_a == 8'd7) begin found = 1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        checks++; if (!found || sv_a !== 1'b0 || idx_a !== 8'd7 || busy_a !== 1'b1) begin
            errors++; $display("FAIL rst_gap: got found=%b v=%b idx=%0d want gap of vector 7", found, sv_a, idx_a); end
        rst = 1;
        @(negedge clk);
        checks++; if ({so_a, sv_a, busy_a, done_a, pass_a, fe_a, fl_a, idx_a} !== '0) begin
            errors++; $display("FAIL rst_mid: got out=%0h v=%b b=%b d=%b idx=%0d want all 0", so_a, sv_a, busy_a, done_a, idx_a); end
        rst = 0;
        @(negedge clk);
        collect(2000);
        for (int i = 0; i < 16; i++) begin
            checks++; if (got_vec[i] !== gold_vec(i, 5)) begin
                errors++; $display("FAIL rst_replay[%0d]: got %h want %h", i, got_vec[i], gold_vec(i, 5)); end
        end
        checks++; if (pass_a !== 1'b1) begin errors++; $display("FAIL rst_replay_pass: got %b want 1", pass_a); end
    endtask

`ifdef STATE_SEQ_DRIVER_TIMEOUT_EN
    task automatic test_timeout();
        sel = 0; state_ready = 0;
        start_a = 1;
        @(negedge clk);
        start_a = 0;
        done_cnt = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (done_a) done_cnt++;
            state_ready = 0;
            @(negedge clk);
        end
        state_ready = 1;
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL to_done: got %0d want 1", done_cnt); end
        checks++; if ({to_a, fl_a, pass_a, busy_a} !== 4'b1100) begin
            errors++; $display("FAIL to_flags: got to=%b fl=%b pass=%b busy=%b want 1 1 0 0", to_a, fl_a, pass_a, busy_a); end
    endtask
`endif

    initial begin
        rst = 1; start_a = 0; start_n = 0; state_ready = 1; trig_n = 0;
        mon_mode = 0; sel = 0; rand_ready = 0; force_at3 = 0;
        repeat (3) @(negedge clk);
        test_reset();
        test_basic();
        test_late();
        test_negative();
        test_backpressure();
        test_reset_mid_run();
`ifdef STATE_SEQ_DRIVER_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
